rw_4x4_sync: RTL and testbench



---
 rtl/rw_mem_pkg.sv | 13 +
 rtl/rw_4x4_sync.sv | 37 +++
 tb/tb_rw_4x4_sync.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rw_mem_pkg.sv
// Shared defaults and types for the small synchronous read/write stores.
package rw_mem_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_ADDR_W = 2;

  typedef logic [DEF_DATA_W-1:0] word_t;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/rw_4x4_sync.sv
// Single-port synchronous memory, 2**ADDR_W words x DATA_W bits, registered read data.
module rw_4x4_sync
  import rw_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  output logic [DATA_W-1:0] data_out,
  input  logic [ADDR_W-1:0] address,
  input  logic              WE,
  input  logic              clk,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rst_n
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Both tests on WE are explicit so an unknown WE neither writes nor reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else if (WE) begin
      mem_q[address] <= data_in;
    end else if (!WE) begin
      rdata_q <= mem_q[address];
    end
  end

  assign data_out = rdata_q;

endmodule

// File: tb/tb_rw_4x4_sync.sv
// Self-checking bench for rw_4x4_sync: vector table through a scoreboard plus corner sequences.
module tb_rw_4x4_sync;

  logic       clk;
  logic       rst_n;
  logic [1:0] address;
  logic       WE;
  logic [3:0] data_in;
  logic [3:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] sb_q[$];

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [3:0] din;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[13];

  rw_4x4_sync #(.DATA_W(4), .ADDR_W(2)) dut (
    .data_out(data_out),
    .address (address),
    .WE      (WE),
    .clk     (clk),
    .data_in (data_in),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n === 1'b1 && $isunknown(WE)) begin
      $error("WE unknown at rising edge");
    end
  end

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: data_out=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, push the expectation, pop and compare just after the rising edge.
  task automatic step(input logic we, input logic [1:0] a, input logic [3:0] d,
                      input logic [3:0] exp, input string nm);
    logic [3:0] e;
    @(negedge clk);
    WE      = we;
    address = a;
    data_in = d;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      check(nm, data_out, e);
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    WE      = 1'b0;
    address = '0;
    data_in = '0;

    vecs[0]  = '{1'b1, 2'd0, 4'h4, 4'h0, "wr0_hold"};
    vecs[1]  = '{1'b1, 2'd1, 4'h1, 4'h0, "wr1_hold"};
    vecs[2]  = '{1'b1, 2'd2, 4'h9, 4'h0, "wr2_hold"};
    vecs[3]  = '{1'b1, 2'd3, 4'h3, 4'h0, "wr3_hold"};
    vecs[4]  = '{1'b0, 2'd0, 4'hC, 4'h4, "rd0"};
    vecs[5]  = '{1'b0, 2'd1, 4'hC, 4'h1, "rd1"};
    vecs[6]  = '{1'b0, 2'd2, 4'hC, 4'h9, "rd2"};
    vecs[7]  = '{1'b0, 2'd3, 4'hC, 4'h3, "rd3"};
    vecs[8]  = '{1'b1, 2'd2, 4'hF, 4'h3, "overwr2_hold"};
    vecs[9]  = '{1'b0, 2'd2, 4'h0, 4'hF, "rd2_overwritten"};
    vecs[10] = '{1'b0, 2'd1, 4'h0, 4'h1, "rd1_untouched"};
    vecs[11] = '{1'b1, 2'd3, 4'hA, 4'h1, "wr3_b2b_hold"};
    vecs[12] = '{1'b0, 2'd3, 4'h0, 4'hA, "rd3_b2b"};

    // Reset asserted mid-cycle takes effect without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", data_out, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'(i), 4'h0, 4'h0, $sformatf("post_reset_rd%0d", i));
    end

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].exp, vecs[i].name);
    end

    // Inter-edge glitch with WE=1: only the values present at the edge are stored.
    @(negedge clk);
    WE      = 1'b1;
    address = 2'd2;
    data_in = 4'hC;
    #2;
    address = 2'd0;
    data_in = 4'h5;
    #2;
    address = 2'd1;
    data_in = 4'h6;
    @(posedge clk);
    #1;
    check("glitch_hold_a", data_out, 4'hA);
    address = 2'd3;
    data_in = 4'hE;
    #2;
    check("glitch_hold_b", data_out, 4'hA);
    address = 2'd0;
    data_in = 4'h7;
    #1;
    check("glitch_hold_c", data_out, 4'hA);
    step(1'b0, 2'd1, 4'h0, 4'h6, "glitch_rd1_stored");
    step(1'b0, 2'd3, 4'h0, 4'hA, "glitch_rd3_unchanged");
    step(1'b0, 2'd0, 4'h0, 4'h4, "glitch_rd0_unchanged");
    step(1'b0, 2'd2, 4'h0, 4'hF, "glitch_rd2_unchanged");

    // Async reset during a read stream, with a write attempted while held.
    #2;
    rst_n = 1'b0;
    #1;
    check("midread_reset_immediate", data_out, 4'h0);
    @(negedge clk);
    WE      = 1'b1;
    address = 2'd0;
    data_in = 4'h7;
    @(posedge clk);
    #1;
    check("reset_held_write_ignored", data_out, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    WE    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'(i), 4'h0, 4'h0, $sformatf("after_reset2_rd%0d", i));
    end
    step(1'b1, 2'd2, 4'h8, 4'h0, "rewrite2_hold");
    step(1'b0, 2'd2, 4'h0, 4'h8, "rewrite2_rd");

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
